// File: rtl/piso_stream.sv
// Streaming parallel-in/serial-out serializer: whole frames in on valid/ready,
// LANES words per beat out on valid/ready, with a one-frame holding slot.
module piso_stream #(
    parameter  int WIDTH     = 8,
    parameter  int NUM_TAPS  = 4,
    parameter  int LANES     = 1,
    parameter  int MSB_FIRST = 1,
    localparam int BEATS     = NUM_TAPS / LANES,
    localparam int IW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clkext,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*NUM_TAPS-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*LANES-1:0]    data_out,
    output logic                      out_last,
    output logic [IW-1:0]             beat_idx,
    output logic [15:0]               frame_cnt
);

    localparam int FW = WIDTH * NUM_TAPS;
    localparam int BW = WIDTH * LANES;
    localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);

    // State encoding is literally {hold valid, active valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic [FW-1:0]   active_reg, hold_reg;
    logic [IW-1:0]   beat_reg, beat_next;
    logic [15:0]     cnt_reg, cnt_next;
    logic            in_ready_reg;
    logic            load_active, load_hold, promote;
    logic            in_fire, out_fire, last_fire, at_last;
    logic [BW-1:0]   slice [BEATS];

    assign out_valid = (state_reg != EMPTY);
    assign at_last   = (beat_reg == LAST_BEAT);
    assign in_fire   = in_valid && in_ready_reg;
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && at_last;

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        cnt_next    = cnt_reg;
        load_active = 1'b0;
        load_hold   = 1'b0;
        promote     = 1'b0;
        if (clr) begin
            state_next = EMPTY;
            beat_next  = '0;
            cnt_next   = '0;
        end else begin
            if (out_fire) begin
                beat_next = at_last ? '0 : beat_reg + 1'b1;
            end
            if (last_fire) begin
                cnt_next = cnt_reg + 16'd1;
            end
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        load_active = 1'b1;
                        state_next  = BUSY;
                    end
                end
                BUSY: begin
                    // A frame arriving alongside the last beat goes straight to ACTIVE.
                    if (last_fire) begin
                        if (in_fire) begin
                            load_active = 1'b1;
                        end else begin
                            state_next = EMPTY;
                        end
                    end else if (in_fire) begin
                        load_hold  = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (last_fire) begin
                        promote    = 1'b1;
                        state_next = BUSY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clkext or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            beat_reg     <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            cnt_reg      <= cnt_next;
            in_ready_reg <= (state_next != FULL);
        end
    end

    // Frame payload needs no reset: data_out is gated by out_valid.
    always_ff @(posedge clkext) begin
        if (load_active) begin
            active_reg <= data_in;
        end else if (promote) begin
            active_reg <= hold_reg;
        end
        if (load_hold) begin
            hold_reg <= data_in;
        end
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
        localparam int SEL = (MSB_FIRST != 0) ? (BEATS - 1 - gi) : gi;
        assign slice[gi] = active_reg[BW*SEL +: BW];
    end

    assign data_out  = out_valid ? slice[beat_reg] : '0;
    assign out_last  = out_valid && at_last;
    assign beat_idx  = beat_reg;
    assign frame_cnt = cnt_reg;
    assign in_ready  = in_ready_reg;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: directed frames with literal expectations,
// then randomized traffic checked every cycle against a queue-based frame model.
module tb_piso_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_last;
    logic [7:0]  data_out;
    logic [1:0]  beat_idx;
    logic [15:0] frame_cnt;

    logic        lsb_in_ready, lsb_out_valid, lsb_out_last;
    logic [7:0]  lsb_data_out;
    logic [1:0]  lsb_beat_idx;
    logic [15:0] lsb_frame_cnt;

    logic        l2_in_ready, l2_out_valid, l2_out_last;
    logic [15:0] l2_data_out;
    logic [0:0]  l2_beat_idx;
    logic [15:0] l2_frame_cnt;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(8), .NUM_TAPS(4), .LANES(1), .MSB_FIRST(1)) u_dut (
        .clkext(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_last(out_last), .beat_idx(beat_idx), .frame_cnt(frame_cnt)
    );

    piso_stream #(.WIDTH(8), .NUM_TAPS(4), .LANES(1), .MSB_FIRST(0)) u_lsb (
        .clkext(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(lsb_in_ready),
        .data_in(data_in), .out_valid(lsb_out_valid), .out_ready(out_ready), .data_out(lsb_data_out),
        .out_last(lsb_out_last), .beat_idx(lsb_beat_idx), .frame_cnt(lsb_frame_cnt)
    );

    piso_stream #(.WIDTH(8), .NUM_TAPS(4), .LANES(2), .MSB_FIRST(1)) u_l2 (
        .clkext(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(l2_in_ready),
        .data_in(data_in), .out_valid(l2_out_valid), .out_ready(out_ready), .data_out(l2_data_out),
        .out_last(l2_out_last), .beat_idx(l2_beat_idx), .frame_cnt(l2_frame_cnt)
    );

    // Model of the main instance: queued frames, position within the head frame.
    logic [31:0] q [$];
    int          k = 0;
    logic [15:0] cnt = '0;
    logic        exp_ready = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic compare();
        int sel;
        logic [7:0] exp_d;
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, (q.size() > 0));
        chk("frame_cnt", frame_cnt, cnt);
        if (q.size() > 0) begin
            sel   = 3 - k;
            exp_d = 8'(q[0] >> (8 * sel));
            chk("data_out", data_out, exp_d);
            chk("beat_idx", beat_idx, k);
            chk("out_last", out_last, (k == 3));
        end else begin
            chk("out_last_idle", out_last, 1'b0);
        end
    endtask

    // Compare the current outputs, drive one cycle of inputs, advance the model.
    task automatic step(input logic c, input logic iv, input logic [31:0] d,
                        input logic ordy, output logic fired);
        compare();
        clr       = c;
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        fired     = !c && iv && exp_ready;
        if (c) begin
            q.delete();
            k         = 0;
            cnt       = '0;
            exp_ready = 1'b1;
        end else begin
            if (q.size() > 0 && ordy) begin
                if (k == 3) begin
                    $display("frame done: %08h frame_cnt=%0d", q[0], cnt + 16'd1);
                    void'(q.pop_front());
                    k   = 0;
                    cnt = cnt + 16'd1;
                end else begin
                    k++;
                end
            end
            if (fired) q.push_back(d);
            exp_ready = (q.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_beat_idx", beat_idx, 2'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
    endtask

    initial begin
        logic        f;
        logic [31:0] fr [4];
        int          idx, run, maxrun;
        logic        saw_full;

        fr[0] = 32'h44332211;
        fr[1] = 32'h88776655;
        fr[2] = 32'hCCBBAA99;
        fr[3] = 32'h0;

        // Reset and first edge after release
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("in_ready_before_edge", in_ready, 1'b0);
        step(0, 0, 32'h0, 0, f);
        chk("in_ready_after_edge", in_ready, 1'b1);

        // Single frame, all three instances in lockstep
        step(0, 1, 32'h44332211, 1, f);
        chk("msb_b0", data_out, 8'h44);
        chk("lsb_b0", lsb_data_out, 8'h11);
        chk("l2_b0", l2_data_out, 16'h4433);
        chk("l2_idx0", l2_beat_idx, 1'b0);
        chk("l2_last0", l2_out_last, 1'b0);
        step(0, 0, 32'h0, 1, f);
        chk("msb_b1", data_out, 8'h33);
        chk("lsb_b1", lsb_data_out, 8'h22);
        chk("l2_b1", l2_data_out, 16'h2211);
        chk("l2_idx1", l2_beat_idx, 1'b1);
        chk("l2_last1", l2_out_last, 1'b1);
        step(0, 0, 32'h0, 1, f);
        chk("msb_b2", data_out, 8'h22);
        chk("lsb_b2", lsb_data_out, 8'h33);
        chk("l2_done_valid", l2_out_valid, 1'b0);
        chk("l2_cnt", l2_frame_cnt, 16'd1);
        step(0, 0, 32'h0, 1, f);
        chk("msb_b3", data_out, 8'h11);
        chk("msb_last3", out_last, 1'b1);
        chk("lsb_b3", lsb_data_out, 8'h44);
        chk("cnt_before_last", frame_cnt, 16'd0);
        step(0, 0, 32'h0, 1, f);
        chk("cnt_after_last", frame_cnt, 16'd1);
        chk("idle_valid", out_valid, 1'b0);

        // Backpressure on beat 1
        step(0, 1, 32'h44332211, 1, f);
        step(0, 0, 32'h0, 1, f);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, f);
            chk("bp_data", data_out, 8'h33);
            chk("bp_idx", beat_idx, 2'd1);
        end
        step(0, 0, 32'h0, 1, f);
        chk("bp_resume", data_out, 8'h22);
        step(0, 0, 32'h0, 1, f);
        step(0, 0, 32'h0, 1, f);

        // Back-to-back frames after a clear
        step(1, 0, 32'h0, 1, f);
        idx = 0; run = 0; maxrun = 0; saw_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(0, (idx < 3), fr[idx], 1, f);
            if (f) idx++;
            if (out_valid) run++; else run = 0;
            if (run > maxrun) maxrun = run;
            if (!in_ready) saw_full = 1'b1;
        end
        chk("b2b_run", maxrun, 12);
        chk("b2b_full_seen", saw_full, 1'b1);
        chk("b2b_cnt", frame_cnt, 16'd3);

        // Clear mid-frame with a frame in HOLD
        step(0, 1, 32'h44332211, 1, f);
        step(0, 1, 32'h88776655, 1, f);
        chk("clr_pre_data", data_out, 8'h33);
        chk("clr_pre_ready", in_ready, 1'b0);
        step(1, 1, 32'hCCBBAA99, 1, f);
        chk("clr_valid", out_valid, 1'b0);
        chk("clr_cnt", frame_cnt, 16'd0);
        chk("clr_ready", in_ready, 1'b1);
        step(0, 1, 32'hDDCCBBAA, 1, f);
        chk("clr_next_b0", data_out, 8'hDD);
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 1, f);

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                while (q.size() == 0 || k == 0) step(0, 1, $urandom, 1'($urandom_range(0, 1)), f);
                clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs();
                q.delete(); k = 0; cnt = '0; exp_ready = 1'b0;
                @(negedge clk);
                compare();
                #2 rst_n = 1'b1;
                #1 chk("rst_mid_ready_hold", in_ready, 1'b0);
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, 3) != 0), f);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 1, f);
        compare();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out streaming serializer for the NPU output path. It takes whole frames of NUM_TAPS words on a valid/ready input and emits them LANES words per beat on a valid/ready output. A one-frame holding buffer lets frames stream back-to-back with no gaps, and output backpressure stalls the shift. It supersedes the fixed single-lane PISO and adds handshaking, a selectable shift direction, multi-lane output and a completed-frame counter.

## Interface

- WIDTH, 8: bits per word.
- NUM_TAPS, 4: words per frame; must be an integer multiple of LANES.
- LANES, 1: words per output beat. BEATS = NUM_TAPS/LANES. IW = max(1, $clog2(BEATS)).
- MSB_FIRST, 1: 1 sends the highest-index slice first; 0 sends the lowest-index slice first.
- CLKEXT, in, 1: the single clock; all state changes on its rising edge.
- RST_N, in, 1: asynchronous, active-low reset.
- CLR, in, 1: synchronous clear, active high.
- IN_VALID, in, 1: DATA_IN holds a frame.
- IN_READY, out, 1: registered; the block can accept a frame.
- DATA_IN, in, WIDTH*NUM_TAPS: frame; word i is at [WIDTH*i +: WIDTH].
- OUT_VALID, out, 1: DATA_OUT holds a valid beat.
- OUT_READY, in, 1: the downstream block accepts the beat.
- DATA_OUT, out, WIDTH*LANES: current beat.
- OUT_LAST, out, 1: the current beat is the last beat of its frame.
- BEAT_IDX, out, IW: index of the current beat, 0..BEATS-1.
- FRAME_CNT, out, 16: number of completed frames; wraps at 2^16.

## Operation

- The block holds two frame slots: ACTIVE (the frame being shifted) and HOLD (the next frame).
- State is encoded by the slot valid bits:
  - EMPTY: neither slot valid.
  - BUSY: ACTIVE valid, HOLD empty.
  - FULL: both slots valid.
- An input transfer happens when IN_VALID && IN_READY. An output transfer happens when OUT_VALID && OUT_READY.
- Input accept routing:
  - If ACTIVE is empty, or ACTIVE's last beat transfers in the same cycle, the frame loads into ACTIVE.
  - Otherwise the frame loads into HOLD.
- On the last-beat transfer with HOLD valid, HOLD moves to ACTIVE and HOLD becomes empty. BEAT_IDX returns to 0 in all cases.
- Beat k, MSB_FIRST=1: DATA_OUT = frame[WIDTH*LANES*(BEATS-1-k) +: WIDTH*LANES].
- Beat k, MSB_FIRST=0: DATA_OUT = frame[WIDTH*LANES*k +: WIDTH*LANES].
- OUT_LAST = OUT_VALID && (BEAT_IDX == BEATS-1). When BEATS=1, every beat is last.
- While OUT_VALID && !OUT_READY, DATA_OUT, BEAT_IDX and OUT_LAST hold stable.
- OUT_VALID is never withdrawn without an output transfer, except on CLR or reset.
- IN_READY is registered. Its next value is !(HOLD valid after this edge).
- FRAME_CNT increments by 1 on each last-beat output transfer.
- CLR has priority over all other activity:
  - both slots empty, OUT_VALID=0, BEAT_IDX=0, FRAME_CNT=0;
  - any input presented in the same cycle is dropped;
  - IN_READY=1 after the edge.

## Timing

- RST_N low sets, immediately and asynchronously: IN_READY=0, OUT_VALID=0, DATA_OUT=0, OUT_LAST=0, BEAT_IDX=0, FRAME_CNT=0, slots empty.
- IN_READY rises on the first CLKEXT edge after RST_N is released.
- Latency: a frame accepted into an EMPTY block at edge N gives OUT_VALID=1 with beat 0 from edge N onward; its first output transfer can occur at edge N+1.
- Throughput: with OUT_READY held high, one beat per cycle. Consecutive frames produce no bubble between the OUT_LAST beat and the next beat 0.
- In FULL, IN_READY=0. It returns to 1 at the edge where ACTIVE's last beat transfers.
- If a frame is accepted in the same cycle as that transfer (IN_READY was 0, so only possible from BUSY), the new frame enters ACTIVE directly.
- When RST_N is asserted mid-frame, the frame is lost. No partial beats are emitted after reset.

## Test plan

- Frame order, MSB_FIRST: WIDTH=8, NUM_TAPS=4, LANES=1, MSB_FIRST=1, DATA_IN=0x44332211, OUT_READY=1 -> DATA_OUT 0x44, 0x33, 0x22, 0x11 on consecutive cycles; OUT_LAST only on 0x11; FRAME_CNT goes 0 -> 1.
- Direction and lanes: MSB_FIRST=0 with the same frame -> 0x11, 0x22, 0x33, 0x44. LANES=2, MSB_FIRST=1 -> 0x4433 then 0x2211, with BEAT_IDX 0, 1.
- Back-to-back frames: IN_VALID held high with frames 0x44332211, 0x88776655, 0xCCBBAA99 -> 12 consecutive beats with no gap; IN_READY low while FULL; FRAME_CNT=3.
- Backpressure: OUT_READY low for 3 cycles while beat 1 is presented -> DATA_OUT held at 0x33 with BEAT_IDX=1; stream resumes with 0x22 when OUT_READY returns high.
- CLR mid-frame: CLR pulsed after beat 0x33 with a frame in HOLD -> OUT_VALID=0, FRAME_CNT=0, IN_READY=1 next cycle; the following frame 0xDDCCBBAA streams correctly starting from 0xDD.
- Async reset mid-frame: RST_N pulsed low between clock edges -> outputs go to their reset values immediately; IN_READY stays 0 until the first edge after release.
